// File: rtl/imap_biu_pkg.sv
// Shared definitions for the input feature map BIU: FSM encodings and the
// width of the per-transfer word count.
package imap_biu_pkg;

   localparam int TOTAL_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/imap_rdata_fifo.sv
// Synchronous response buffer between the arbiter read path and the line buffer.
// DEPTH must be a power of two so the pointers wrap naturally.
module imap_rdata_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          rd_en_i,
   output logic [DW-1:0] rd_data_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_ok;
   logic          rd_ok;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign wr_ok     = wr_en_i & ~full_o;
   assign rd_ok     = rd_en_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is visible while the count is zero.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/imap_biu.sv
// Input feature map BIU: issues map_size*in_ch sequential word reads to the arbiter
// under a credit limit and streams the in-order responses to the line buffer.
module imap_biu
   import imap_biu_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    in_ch,
   input  logic [15:0]   map_size,
   input  logic [AW-1:0] imap_base_addr,
   input  logic          conv_start,
   output logic          imap_biu2arb_req,
   output logic [AW-1:0] imap_biu2arb_addr,
   output logic          imap_biu2arb_vld,
   input  logic          imap_biu2arb_rdy,
   input  logic [DW-1:0] arb2imap_biu_rdata,
   input  logic          arb2imap_biu_rvld,
   output logic [DW-1:0] imap_biu2lbuf_data,
   output logic          imap_biu2lbuf_vld,
   input  logic          imap_biu2lbuf_rdy,
   output logic          imap_done,
   output logic          imap_err,
   output logic [1:0]    imap_dbg_state
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Handshakes: a command transfers on a cycle with vld & rdy; vld and addr hold
   // until then. The lbuf stream pops on vld & rdy. Responses are never stalled.
   state_e             state_q, state_d;
   logic [TOTAL_W-1:0] total_q, total_d;
   logic [TOTAL_W-1:0] issued_q, issued_d;
   logic [TOTAL_W-1:0] popped_q, popped_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [CW-1:0]      outst_q, outst_d;
   logic               pend_q, pend_d;
   logic               err_q, err_d;
   logic               done_q;
   logic               rst_d1_q;

   logic [TOTAL_W-1:0] start_total;
   logic [CW:0]        credit_used;
   logic               credit_ok;
   logic               cmd_vld;
   logic               cmd_hs;
   logic               rsp_ok;
   logic               rsp_bad;
   logic               pop;
   logic [DW-1:0]      fifo_head;
   logic [CW-1:0]      fifo_count;
   logic               fifo_full;
   logic               fifo_empty;

   assign start_total = {8'd0, map_size} * {16'd0, in_ch};
   assign credit_used = {1'b0, outst_q} + {1'b0, fifo_count};
   assign credit_ok   = (credit_used < (CW + 1)'(FIFO_DEPTH));
   assign cmd_vld     = (state_q == ST_RUN) && (pend_q || credit_ok);
   assign cmd_hs      = cmd_vld & imap_biu2arb_rdy;
   // Responses in the first cycle out of reset belong to an aborted transfer.
   assign rsp_ok      = arb2imap_biu_rvld & ~rst_d1_q & (outst_q != '0);
   assign rsp_bad     = arb2imap_biu_rvld & ~rst_d1_q & (outst_q == '0);
   assign pop         = ~fifo_empty & imap_biu2lbuf_rdy;

   imap_rdata_fifo #(
      .DW    (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (rsp_ok),
      .wr_data_i (arb2imap_biu_rdata),
      .rd_en_i   (pop),
      .rd_data_o (fifo_head),
      .count_o   (fifo_count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      total_d  = total_q;
      issued_d = issued_q;
      popped_d = popped_q + {{(TOTAL_W-1){1'b0}}, pop};
      addr_d   = addr_q;
      pend_d   = cmd_vld & ~imap_biu2arb_rdy;
      err_d    = err_q | rsp_bad;
      case ({cmd_hs, rsp_ok})
         2'b10:   outst_d = outst_q + CW'(1);
         2'b01:   outst_d = outst_q - CW'(1);
         default: outst_d = outst_q;
      endcase
      case (state_q)
         ST_IDLE: begin
            if (conv_start) begin
               total_d  = start_total;
               issued_d = '0;
               popped_d = '0;
               addr_d   = imap_base_addr;
               state_d  = (start_total == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (cmd_hs) begin
               addr_d   = addr_q + AW'(1);
               issued_d = issued_q + TOTAL_W'(1);
               if (issued_q == total_q - TOTAL_W'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((outst_q == '0) && fifo_empty && (popped_q == total_q)) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         total_q  <= '0;
         issued_q <= '0;
         popped_q <= '0;
         addr_q   <= '0;
         outst_q  <= '0;
         pend_q   <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         rst_d1_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         total_q  <= total_d;
         issued_q <= issued_d;
         popped_q <= popped_d;
         addr_q   <= addr_d;
         outst_q  <= outst_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
         done_q   <= (state_q == ST_DONE);
         rst_d1_q <= 1'b0;
      end
   end

   assign imap_biu2arb_req   = (state_q == ST_RUN);
   assign imap_biu2arb_addr  = addr_q;
   assign imap_biu2arb_vld   = cmd_vld;
   assign imap_biu2lbuf_vld  = ~fifo_empty;
   assign imap_biu2lbuf_data = fifo_empty ? '0 : fifo_head;
   assign imap_done          = done_q;
   assign imap_err           = err_q;
   assign imap_dbg_state     = state_q;

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_imap_biu.sv
// Directed bench for imap_biu: arbiter/memory responder, line-buffer sink and
// expected address/data queues checked every cycle.
module tb_imap_biu;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_ch;
  logic [15:0] map_size;
  logic [31:0] imap_base_addr;
  logic        conv_start;
  logic        arb_req;
  logic [31:0] arb_addr;
  logic        arb_vld;
  logic        arb_rdy;
  logic [31:0] rdata;
  logic        rvld;
  logic [31:0] lbuf_data;
  logic        lbuf_vld;
  logic        lbuf_rdy;
  logic        imap_done;
  logic        imap_err;
  logic [1:0]  dbg_state;

  imap_biu #(.AW(32), .DW(32), .FIFO_DEPTH(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_ch              (in_ch),
    .map_size           (map_size),
    .imap_base_addr     (imap_base_addr),
    .conv_start         (conv_start),
    .imap_biu2arb_req   (arb_req),
    .imap_biu2arb_addr  (arb_addr),
    .imap_biu2arb_vld   (arb_vld),
    .imap_biu2arb_rdy   (arb_rdy),
    .arb2imap_biu_rdata (rdata),
    .arb2imap_biu_rvld  (rvld),
    .imap_biu2lbuf_data (lbuf_data),
    .imap_biu2lbuf_vld  (lbuf_vld),
    .imap_biu2lbuf_rdy  (lbuf_rdy),
    .imap_done          (imap_done),
    .imap_err           (imap_err),
    .imap_dbg_state     (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] rsp_data_q[$];
  int          rsp_due_q[$];

  int          cyc = 0;
  int          lat = 2;
  int          n_cmd, n_pop, n_done;
  bit          rdy_rand, lbuf_rand, lbuf_fix;
  bit          saw_req, saw_vld, stall_prev;
  logic [31:0] stall_addr;
  logic        s_req, s_vld, s_lvld, s_done, s_err;
  logic [31:0] s_addr, s_ldata;
  logic [1:0]  s_state;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // one clock: sample at negedge, check handshakes, drive inputs after posedge
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    s_req = arb_req;  s_vld = arb_vld;  s_addr = arb_addr;
    s_lvld = lbuf_vld; s_ldata = lbuf_data; s_done = imap_done;
    s_err = imap_err; s_state = dbg_state;
    if (stall_prev) begin
      chk("hold_vld", {31'd0, arb_vld}, 32'd1);
      chk("hold_addr", arb_addr, stall_addr);
    end
    stall_prev = arb_vld && !arb_rdy;
    stall_addr = arb_addr;
    if (arb_vld && arb_rdy) begin
      chk("cmd_expected", {31'd0, exp_addr_q.size() != 0}, 32'd1);
      if (exp_addr_q.size() != 0) begin
        e = exp_addr_q.pop_front();
        chk("cmd_addr", arb_addr, e);
      end
      rsp_data_q.push_back(mem_word(arb_addr));
      rsp_due_q.push_back(cyc + lat);
      n_cmd++;
    end
    if (lbuf_vld && lbuf_rdy) begin
      chk("pop_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("lbuf_data", lbuf_data, e);
      end
      n_pop++;
    end
    if (imap_done) n_done++;
    if (arb_req) saw_req = 1'b1;
    if (arb_vld) saw_vld = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    arb_rdy  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    lbuf_rdy = lbuf_rand ? 1'($urandom_range(0, 1)) : lbuf_fix;
    if (rsp_due_q.size() != 0 && rsp_due_q[0] <= cyc) begin
      rvld  = 1'b1;
      rdata = rsp_data_q.pop_front();
      void'(rsp_due_q.pop_front());
    end else begin
      rvld  = 1'b0;
      rdata = '0;
    end
  endtask

  // driver: load expectations and pulse conv_start, then scramble the parameters
  task automatic start(input logic [7:0] ch, input logic [15:0] ms, input logic [31:0] base);
    int unsigned tot;
    tot = ch * ms;
    for (int i = 0; i < int'(tot); i++) begin
      exp_addr_q.push_back(base + 32'(i));
      exp_q.push_back(mem_word(base + 32'(i)));
    end
    n_cmd = 0; n_pop = 0; n_done = 0;
    saw_req = 1'b0; saw_vld = 1'b0;
    in_ch = ch; map_size = ms; imap_base_addr = base;
    conv_start = 1'b1;
    tick();
    conv_start = 1'b0;
    in_ch = 8'($urandom); map_size = 16'($urandom); imap_base_addr = $urandom;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      tick();
      k++;
    end
    chk("done_seen", {31'd0, n_done != 0}, 32'd1);
  endtask

  task automatic flush();
    exp_addr_q.delete(); exp_q.delete();
    rsp_data_q.delete(); rsp_due_q.delete();
    stall_prev = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_ch = '0; map_size = '0; imap_base_addr = '0; conv_start = 1'b0;
    arb_rdy = 1'b1; rdata = '0; rvld = 1'b0; lbuf_rdy = 1'b1;
    rdy_rand = 1'b0; lbuf_rand = 1'b0; lbuf_fix = 1'b1; stall_prev = 1'b0;
    tick(); tick();
    chk("rst_req", {31'd0, s_req}, 32'd0);
    chk("rst_vld", {31'd0, s_vld}, 32'd0);
    chk("rst_lvld", {31'd0, s_lvld}, 32'd0);
    chk("rst_done", {31'd0, s_done}, 32'd0);
    chk("rst_err", {31'd0, s_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: basic 2x3 transfer
    lat = 2;
    start(8'd2, 16'd3, 32'h100);
    tick();
    chk("t1_first_vld", {31'd0, s_vld}, 32'd1);
    wait_done(100);
    tick(); tick(); tick();
    chk("t1_cmds", n_cmd, 32'd6);
    chk("t1_pops", n_pop, 32'd6);
    chk("t1_done_once", n_done, 32'd1);
    chk("t1_addr_left", exp_addr_q.size(), 32'd0);
    chk("t1_req_low", {31'd0, s_req}, 32'd0);
    chk("t1_err", {31'd0, s_err}, 32'd0);

    // 2: sink stalled -> credit limit caps commands at FIFO depth
    lbuf_fix = 1'b0;
    start(8'd3, 16'd2, 32'h200);
    repeat (15) tick();
    chk("t2_cmds_capped", n_cmd, 32'd4);
    chk("t2_vld_low", {31'd0, s_vld}, 32'd0);
    chk("t2_lvld", {31'd0, s_lvld}, 32'd1);
    chk("t2_no_pops", n_pop, 32'd0);
    lbuf_fix = 1'b1;
    wait_done(100);
    tick(); tick();
    chk("t2_cmds", n_cmd, 32'd6);
    chk("t2_pops", n_pop, 32'd6);
    chk("t2_data_left", exp_q.size(), 32'd0);

    // 3: random stalls both sides, address wraps past 0xFFFFFFFF
    rdy_rand = 1'b1; lbuf_rand = 1'b1; lat = 3;
    start(8'd3, 16'd5, 32'hFFFF_FFFC);
    wait_done(1000);
    rdy_rand = 1'b0; lbuf_rand = 1'b0; lbuf_fix = 1'b1;
    tick(); tick();
    chk("t3_cmds", n_cmd, 32'd15);
    chk("t3_pops", n_pop, 32'd15);
    chk("t3_addr_left", exp_addr_q.size(), 32'd0);
    chk("t3_done_once", n_done, 32'd1);

    // 4: zero-size map
    lat = 2;
    start(8'd4, 16'd0, 32'h300);
    tick();
    chk("t4_done_early", {31'd0, s_done}, 32'd0);
    tick();
    chk("t4_done_pulse", {31'd0, s_done}, 32'd1);
    tick();
    chk("t4_done_end", {31'd0, s_done}, 32'd0);
    chk("t4_no_req", {31'd0, saw_req}, 32'd0);
    chk("t4_no_vld", {31'd0, saw_vld}, 32'd0);

    // 5: reset with three reads in flight
    lat = 8;
    start(8'd2, 16'd3, 32'h400);
    tick(); tick(); tick();
    chk("t5_in_flight", n_cmd, 32'd3);
    rst_n = 1'b0;
    tick();
    flush();
    rst_n = 1'b1;
    rvld = 1'b1; rdata = 32'hBAD0_BAD0;
    tick();
    chk("t5_req", {31'd0, s_req}, 32'd0);
    chk("t5_vld", {31'd0, s_vld}, 32'd0);
    chk("t5_addr", s_addr, 32'd0);
    chk("t5_lvld", {31'd0, s_lvld}, 32'd0);
    chk("t5_ldata", s_ldata, 32'd0);
    chk("t5_done", {31'd0, s_done}, 32'd0);
    chk("t5_state", {30'd0, s_state}, 32'd0);
    tick();
    chk("t5_stray_err", {31'd0, s_err}, 32'd0);
    chk("t5_stray_lvld", {31'd0, s_lvld}, 32'd0);
    lat = 2;
    start(8'd1, 16'd4, 32'h500);
    wait_done(100);
    tick(); tick();
    chk("t5_cmds", n_cmd, 32'd4);
    chk("t5_pops", n_pop, 32'd4);
    chk("t5_err_clean", {31'd0, s_err}, 32'd0);

    // 6: spurious response while idle
    rvld = 1'b1; rdata = 32'h1234_5678;
    tick();
    tick();
    chk("t6_err_set", {31'd0, s_err}, 32'd1);
    chk("t6_lvld", {31'd0, s_lvld}, 32'd0);
    repeat (5) tick();
    chk("t6_err_sticky", {31'd0, s_err}, 32'd1);
    chk("t6_lvld_still", {31'd0, s_lvld}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
